// File: rtl/seg7_hex_encoder_if.sv
// Segment-readback bus: raw segment input, nibble handshake, and status/history outputs.
interface seg7_hex_encoder_if #(
  parameter int DIGITS = 4,
  parameter int ERR_W  = 8
);
  logic [6:0]          SEG;
  logic                HEX_READY;
  logic [3:0]          HEX_OUT;
  logic                HEX_VALID;
  logic                BLANK;
  logic                ERR;
  logic [ERR_W-1:0]    ERR_COUNT;
  logic [4*DIGITS-1:0] HISTORY;

  modport slave (
    input  SEG, HEX_READY,
    output HEX_OUT, HEX_VALID, BLANK, ERR, ERR_COUNT, HISTORY
  );

  modport master (
    output SEG, HEX_READY,
    input  HEX_OUT, HEX_VALID, BLANK, ERR, ERR_COUNT, HISTORY
  );
endinterface

// File: rtl/seg7_hex_encoder.sv
// Reads a 7-segment bus back into hex nibbles: stability filter, glyph encoder,
// valid/ready output stage, error counting and a short digit history.
module seg7_hex_encoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int DIGITS        = 4,
  parameter int ERR_W         = 8
) (
  input  logic                CLOCK_50,
  input  logic                RESET,
  seg7_hex_encoder_if.slave   bus
);

  localparam logic [7:0] STAB = 8'(STABLE_CYCLES);
  localparam int         HW   = 4 * DIGITS;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           r_state, w_state_nxt;
  logic [6:0]       r_seg_q;
  logic [7:0]       r_stab_cnt, w_stab_nxt;
  logic [6:0]       r_acc_seg, w_acc_nxt;
  logic [3:0]       r_hex_out, w_hex_out_nxt;
  logic             r_hex_valid, w_hex_valid_nxt;
  logic             r_blank, w_blank_nxt;
  logic             r_err, w_err_nxt;
  logic [ERR_W-1:0] r_err_cnt, w_err_cnt_nxt;
  logic [HW-1:0]    r_history, w_history_nxt, w_history_push;

  logic       w_accept;
  logic [3:0] w_code;
  logic       w_glyph_ok;
  logic       w_glyph_blank;

  // Counter reloads to 1 on any change so a fresh pattern needs STABLE_CYCLES-1 more matches.
  always_comb begin
    w_stab_nxt = 8'd1;
    if (bus.SEG == r_seg_q)
      w_stab_nxt = (r_stab_cnt >= STAB) ? STAB : r_stab_cnt + 8'd1;
  end

  assign w_accept = (r_stab_cnt == STAB) && (r_seg_q != r_acc_seg) && (r_state == IDLE);

  always_comb begin
    w_code        = 4'h0;
    w_glyph_ok    = 1'b1;
    w_glyph_blank = 1'b0;
    case (r_seg_q)
      7'h3F: w_code = 4'h0;
      7'h06: w_code = 4'h1;
      7'h5B: w_code = 4'h2;
      7'h4F: w_code = 4'h3;
      7'h66: w_code = 4'h4;
      7'h6D: w_code = 4'h5;
      7'h7D: w_code = 4'h6;
      7'h07: w_code = 4'h7;
      7'h7F: w_code = 4'h8;
      7'h6F: w_code = 4'h9;
      7'h77: w_code = 4'hA;
      7'h7C: w_code = 4'hB;
      7'h39: w_code = 4'hC;
      7'h5E: w_code = 4'hD;
      7'h79: w_code = 4'hE;
      7'h71: w_code = 4'hF;
      7'h00: begin
        w_glyph_ok    = 1'b0;
        w_glyph_blank = 1'b1;
      end
      default: w_glyph_ok = 1'b0;
    endcase
  end

  generate
    if (DIGITS > 1) begin : g_hist_shift
      assign w_history_push = {r_history[HW-5:0], w_code};
    end else begin : g_hist_single
      assign w_history_push = w_code;
    end
  endgenerate

  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc_seg;
    w_hex_out_nxt   = r_hex_out;
    w_hex_valid_nxt = r_hex_valid;
    w_blank_nxt     = r_blank;
    w_err_nxt       = 1'b0;
    w_err_cnt_nxt   = r_err_cnt;
    w_history_nxt   = r_history;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_acc_nxt = r_seg_q;
          if (w_glyph_ok) begin
            w_hex_out_nxt   = w_code;
            w_hex_valid_nxt = 1'b1;
            w_history_nxt   = w_history_push;
            w_blank_nxt     = 1'b0;
            w_state_nxt     = EMIT;
          end else if (w_glyph_blank) begin
            w_blank_nxt = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
            if (r_err_cnt != '1)
              w_err_cnt_nxt = r_err_cnt + 1'b1;
          end
        end
      end
      EMIT: begin
        // Output held until taken; the filter keeps tracking SEG meanwhile.
        if (bus.HEX_READY) begin
          w_hex_valid_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_seg_q     <= 7'h00;
      r_stab_cnt  <= 8'd0;
      r_acc_seg   <= 7'h00;
      r_hex_out   <= 4'h0;
      r_hex_valid <= 1'b0;
      r_blank     <= 1'b1;
      r_err       <= 1'b0;
      r_err_cnt   <= '0;
      r_history   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_seg_q     <= bus.SEG;
      r_stab_cnt  <= w_stab_nxt;
      r_acc_seg   <= w_acc_nxt;
      r_hex_out   <= w_hex_out_nxt;
      r_hex_valid <= w_hex_valid_nxt;
      r_blank     <= w_blank_nxt;
      r_err       <= w_err_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
      r_history   <= w_history_nxt;
    end
  end

  assign bus.HEX_OUT   = r_hex_out;
  assign bus.HEX_VALID = r_hex_valid;
  assign bus.BLANK     = r_blank;
  assign bus.ERR       = r_err;
  assign bus.ERR_COUNT = r_err_cnt;
  assign bus.HISTORY   = r_history;

endmodule

// File: tb/tb_seg7_hex_encoder.sv
// Directed bench for seg7_hex_encoder; edges are counted from the first edge that sees a new SEG.
module tb_seg7_hex_encoder;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  seg7_hex_encoder_if #(.DIGITS(4), .ERR_W(8)) bus ();

  seg7_hex_encoder #(.STABLE_CYCLES(4), .DIGITS(4), .ERR_W(8)) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_hex_out", 32'(bus.HEX_OUT),   32'h0);
    chk("rst_valid",   32'(bus.HEX_VALID), 32'h0);
    chk("rst_blank",   32'(bus.BLANK),     32'h1);
    chk("rst_err",     32'(bus.ERR),       32'h0);
    chk("rst_errcnt",  32'(bus.ERR_COUNT), 32'h0);
    chk("rst_history", 32'(bus.HISTORY),   32'h0);
  endtask

  logic [6:0] glyphs [5] = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D};

  initial begin
    rst = 1'b1;
    bus.SEG = 7'h00;
    bus.HEX_READY = 1'b0;
    step(); step();
    chk_reset_vals();

    // 1: digit 3 appears on the fifth edge and is consumed on the sixth
    rst = 1'b0; bus.SEG = 7'h4F; bus.HEX_READY = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("t1_early_valid", 32'(bus.HEX_VALID), 32'h0);
    end
    step();
    chk("t1_valid",   32'(bus.HEX_VALID), 32'h1);
    chk("t1_out",     32'(bus.HEX_OUT),   32'h3);
    chk("t1_history", 32'(bus.HISTORY),   32'h0003);
    chk("t1_blank",   32'(bus.BLANK),     32'h0);
    step();
    chk("t1_drop",    32'(bus.HEX_VALID), 32'h0);

    // 2: short 06 glitch is filtered, only 2 is emitted
    rst = 1'b1; bus.SEG = 7'h00;
    step();
    rst = 1'b0; bus.SEG = 7'h06;
    step(); step();
    bus.SEG = 7'h5B;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("t2_early_valid", 32'(bus.HEX_VALID), 32'h0);
      chk("t2_err",         32'(bus.ERR),       32'h0);
    end
    step();
    chk("t2_valid",   32'(bus.HEX_VALID), 32'h1);
    chk("t2_out",     32'(bus.HEX_OUT),   32'h2);
    chk("t2_history", 32'(bus.HISTORY),   32'h0002);
    step();
    chk("t2_drop",    32'(bus.HEX_VALID), 32'h0);

    // 3: backpressure holds 5 while 66 becomes stable underneath
    bus.SEG = 7'h6D; bus.HEX_READY = 1'b0;
    for (int i = 1; i <= 5; i++) step();
    chk("t3_valid5", 32'(bus.HEX_VALID), 32'h1);
    chk("t3_out5",   32'(bus.HEX_OUT),   32'h5);
    bus.SEG = 7'h66;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("t3_hold_valid", 32'(bus.HEX_VALID), 32'h1);
      chk("t3_hold_out",   32'(bus.HEX_OUT),   32'h5);
    end
    bus.HEX_READY = 1'b1;
    step();
    chk("t3_gap", 32'(bus.HEX_VALID), 32'h0);
    step();
    chk("t3_valid4",  32'(bus.HEX_VALID), 32'h1);
    chk("t3_out4",    32'(bus.HEX_OUT),   32'h4);
    chk("t3_history", 32'(bus.HISTORY),   32'h0254);
    step();
    chk("t3_drop", 32'(bus.HEX_VALID), 32'h0);

    // 4: digits 1..5 separated by blanks, then D
    for (int d = 0; d < 5; d++) begin
      bus.SEG = 7'h00;
      for (int i = 1; i <= 6; i++) step();
      chk("t4_blank_on", 32'(bus.BLANK), 32'h1);
      bus.SEG = glyphs[d];
      for (int i = 1; i <= 5; i++) step();
      chk("t4_valid",     32'(bus.HEX_VALID), 32'h1);
      chk("t4_out",       32'(bus.HEX_OUT),   32'(d + 1));
      chk("t4_blank_off", 32'(bus.BLANK),     32'h0);
      step();
    end
    chk("t4_history", 32'(bus.HISTORY), 32'h2345);
    bus.SEG = 7'h5E;
    for (int i = 1; i <= 5; i++) step();
    chk("t4_out_d",     32'(bus.HEX_OUT), 32'hD);
    chk("t4_history_d", 32'(bus.HISTORY), 32'h345D);
    step();

    // 5: invalid pattern pulses ERR once, then the counter saturates
    bus.SEG = 7'h55;
    for (int i = 1; i <= 4; i++) step();
    chk("t5_err_early", 32'(bus.ERR), 32'h0);
    step();
    chk("t5_err",     32'(bus.ERR),       32'h1);
    chk("t5_errcnt",  32'(bus.ERR_COUNT), 32'h1);
    chk("t5_valid",   32'(bus.HEX_VALID), 32'h0);
    chk("t5_history", 32'(bus.HISTORY),   32'h345D);
    chk("t5_blank",   32'(bus.BLANK),     32'h0);
    step();
    chk("t5_err_pulse", 32'(bus.ERR), 32'h0);
    for (int i = 0; i < 300; i++) begin
      bus.SEG = (i % 2 == 0) ? 7'h2A : 7'h55;
      for (int k = 1; k <= 5; k++) step();
      if (i == 0) chk("t5_errcnt2", 32'(bus.ERR_COUNT), 32'h2);
    end
    chk("t5_sat", 32'(bus.ERR_COUNT), 32'hFF);

    // 6: reset during EMIT drops the digit; 8 comes back five edges after release
    bus.SEG = 7'h7F; bus.HEX_READY = 1'b0;
    for (int i = 1; i <= 5; i++) step();
    chk("t6_valid_pre", 32'(bus.HEX_VALID), 32'h1);
    chk("t6_out_pre",   32'(bus.HEX_OUT),   32'h8);
    rst = 1'b1;
    step();
    chk_reset_vals();
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("t6_early_valid", 32'(bus.HEX_VALID), 32'h0);
    end
    step();
    chk("t6_valid",   32'(bus.HEX_VALID), 32'h1);
    chk("t6_out",     32'(bus.HEX_OUT),   32'h8);
    chk("t6_history", 32'(bus.HISTORY),   32'h0008);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seg7_hex_encoder.md
Name: seg7_hex_encoder

Overview:
- Converts a 7-segment pattern back to a 4-bit hex value; the inverse direction of the team's BCD/hex-to-7-segment decoder.
- Samples a segment bus, filters glitches with a stability counter, and encodes each accepted glyph to a nibble.
- Emits each nibble on a valid/ready handshake and keeps a shift history of recent digits.
- Used to self-check display paths and to read segment buses back from external display controllers.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required before a pattern is accepted (range 2..255).
- DIGITS, 4: number of nibbles kept in HISTORY.
- ERR_W, 8: width of the saturating error counter.

Ports:
- CLOCK_50, input, 1: single system clock; all logic on the rising edge.
- RESET, input, 1: synchronous, active-high reset.
- SEG, input, 7: segment pattern, active-high (1 = segment lit). SEG[0]=a, SEG[1]=b, … SEG[6]=g.
- HEX_READY, input, 1: consumer accepts HEX_OUT.
- HEX_OUT, output, 4: encoded nibble.
- HEX_VALID, output, 1: HEX_OUT holds an unconsumed digit.
- BLANK, output, 1: last accepted pattern was all-off.
- ERR, output, 1: one-cycle pulse when an unrecognised pattern is accepted.
- ERR_COUNT, output, ERR_W: saturating count of accepted invalid patterns.
- HISTORY, output, 4*DIGITS: last DIGITS valid nibbles; newest in [3:0].

Behaviour:
- Glyph table (SEG as hex, g..a):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F
  - A=77, b=7C, C=39, d=5E, E=79, F=71
  - 00 = blank; every other value is invalid.
- Stability filter:
  - seg_q registers SEG each cycle; stab_cnt counts consecutive cycles with SEG == seg_q.
  - stab_cnt reloads to 1 on any mismatch and saturates at STABLE_CYCLES.
- Acceptance: a pattern is accepted when all of the following hold:
  - stab_cnt == STABLE_CYCLES;
  - seg_q != acc_seg (last accepted pattern);
  - state is IDLE.
  - On acceptance, acc_seg <= seg_q.
  - Holding an already-accepted pattern never re-accepts it; repeating a digit requires an intervening different pattern (e.g. blank).
- Latency: with SEG changing before edge 0 and held, acceptance and HEX_VALID occur on rising edge STABLE_CYCLES + 1.
- FSM, states IDLE and EMIT:
  - IDLE, accept valid glyph: HEX_OUT <= code, HEX_VALID <= 1, HISTORY <= {HISTORY[4*DIGITS-5:0], code}, BLANK <= 0, go to EMIT.
  - IDLE, accept blank: BLANK <= 1; no push, no valid; stay in IDLE.
  - IDLE, accept invalid: ERR <= 1 for one cycle; ERR_COUNT += 1, saturating at 2^ERR_W-1; BLANK, HISTORY and HEX_OUT unchanged; stay in IDLE.
  - EMIT: HEX_VALID and HEX_OUT are held stable. When HEX_READY=1 on an edge: HEX_VALID <= 0, go to IDLE.
  - Earliest next acceptance is the edge after the return to IDLE, so HEX_VALID always drops for at least one cycle between digits.
- While in EMIT, the stability filter keeps running.
  - A pattern that is stable and differs from acc_seg when IDLE is re-entered is accepted on that next edge.
  - Intermediate patterns seen during EMIT are lost.
- HEX_READY is ignored while HEX_VALID=0.
- Reset values (RESET=1 takes priority over everything on the same edge):
  - HEX_OUT=0, HEX_VALID=0, BLANK=1, ERR=0, ERR_COUNT=0, HISTORY=0;
  - acc_seg=00, seg_q=00, stab_cnt=0, state IDLE.
  - Reset mid-EMIT drops the pending digit. A nonzero SEG held through reset is re-accepted STABLE_CYCLES + 1 edges after RESET falls.

Test Plan:
1. After reset, SEG=4F held, HEX_READY=1: HEX_VALID high exactly on edge 5; then HEX_OUT=3, HISTORY=0x0003, BLANK=0; HEX_VALID low the next edge.
2. Glitch: SEG=06 for 2 cycles, then 5B held: only digit 2 emitted, HISTORY=0x0002, ERR=0.
3. Backpressure: SEG=6D accepted, HEX_READY=0 for 5 cycles while SEG changes to 66 and holds: HEX_VALID/HEX_OUT=5 stay stable; after HEX_READY=1, 5 is consumed, 4 is emitted after exactly one low cycle of HEX_VALID.
4. Sequence 1,2,3,4,5 separated by blank (00), each held 6 cycles: HISTORY=0x2345; BLANK toggles 1/0 accordingly; SEG=5E → HEX_OUT=D.
5. Invalid: SEG=55 stable: one ERR pulse, ERR_COUNT=1; 300 alternations 55/2A: ERR_COUNT saturates at 255.
6. RESET asserted in EMIT with SEG=7F held: all outputs take reset values next edge; after release, 8 re-emitted on edge 5.
